// File: rtl/uart_imem_loader_pkg.sv
// Shared types and helpers for the UART instruction-memory loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_WAIT_HIGH
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_ACTIVE,
    LD_DONE,
    LD_OVF
  } ld_state_e;

  function automatic int clks_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/uart_imem_loader_if.sv
// Instruction-memory write port driven by the loader.
interface uart_imem_loader_if #(
    parameter int ADDR_W = 8,
    parameter int DW     = 32
);
    // imem_we is a one-cycle write strobe with no backpressure; imem_addr and
    // imem_wdata are meaningful in the strobe cycle and hold their value after it.
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DW-1:0]     imem_wdata;

    modport master (output imem_we, output imem_addr, output imem_wdata);
    modport slave  (input  imem_we, input  imem_addr, input  imem_wdata);
endinterface

// File: rtl/uart_imem_loader_rx_core.sv
// UART receiver: input synchroniser plus frame FSM reporting byte, BREAK and framing error.
module uart_rx_core
    import uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rxd_i,
    input  logic       rx_en_i,
    output logic       valid_o,
    output logic [7:0] data_o,
    output logic       break_o,
    output logic       frame_err_o,
    output rx_state_e  state_o
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    // sync_q[1] is the synchronised line; sync_q[2] is its previous value for edge detection.
    logic [2:0]       sync_q;
    rx_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             break_q, break_d;
    logic             ferr_q, ferr_d;
    logic             rxd_s;
    logic             fall;

    assign rxd_s = sync_q[1];
    assign fall  = sync_q[2] & ~sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= 3'b111;
            state_q <= RX_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            break_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[1:0], rxd_i};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            break_q <= break_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        break_d = 1'b0;
        ferr_d  = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                cnt_d = '0;
                bit_d = '0;
                if (rx_en_i && fall) state_d = RX_START;
            end
            RX_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d   = '0;
                    state_d = rxd_s ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = '0;
                    shift_d = {rxd_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rxd_s) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                        state_d = RX_IDLE;
                    end else if (shift_q == 8'h00) begin
                        // All-zero frame with a low stop bit: line held in BREAK.
                        break_d = 1'b1;
                        state_d = RX_WAIT_HIGH;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = RX_IDLE;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                cnt_d = '0;
                if (rxd_s) state_d = RX_IDLE;
            end
            default: state_d = RX_IDLE;
        endcase
    end

    assign valid_o     = valid_q;
    assign data_o      = data_q;
    assign break_o     = break_q;
    assign frame_err_o = ferr_q;
    assign state_o     = state_q;
endmodule

// File: rtl/uart_imem_loader.sv
// Loads instruction words received over UART into imem; stops on a double terminator word,
// restarts on BREAK, and flags timeouts, framing errors and depth overflow.
module uart_imem_loader
    import uart_loader_pkg::*;
#(
    parameter int                      CLK_HZ       = 50000000,
    parameter int                      BIT_RATE     = 9600,
    parameter int                      WORD_BYTES   = 4,
    parameter int                      ADDR_W       = 8,
    parameter logic [8*WORD_BYTES-1:0] TERM_WORD    = '1,
    parameter int                      TIMEOUT_BITS = 64
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       uart_rxd,
    input  logic                       uart_rx_en,
    output logic                       uart_rx_valid,
    output logic [7:0]                 uart_rx_data,
    output logic                       uart_rx_break,
    uart_imem_loader_if.master         imem,
    output logic [ADDR_W:0]            word_count,
    output logic                       write_done,
    output logic                       load_err,
    output logic                       overflow,
    output rx_state_e                  rx_state_o,
    output ld_state_e                  ld_state_o
);
    localparam int DW        = 8 * WORD_BYTES;
    localparam int CPB       = clks_per_bit(CLK_HZ, BIT_RATE);
    localparam int TMO_LIMIT = TIMEOUT_BITS * CPB;
    localparam int TMO_W     = $clog2(TMO_LIMIT);
    localparam int BI_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int WC_W      = ADDR_W + 1;

    logic       rx_valid, rx_break, rx_ferr;
    logic [7:0] rx_byte;

    uart_rx_core #(.CLKS_PER_BIT(CPB)) u_rx (
        .clk_i      (clk),
        .rst_ni     (resetn),
        .rxd_i      (uart_rxd),
        .rx_en_i    (uart_rx_en),
        .valid_o    (rx_valid),
        .data_o     (rx_byte),
        .break_o    (rx_break),
        .frame_err_o(rx_ferr),
        .state_o    (rx_state_o)
    );

    ld_state_e         ld_state_q, ld_state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BI_W-1:0]   bidx_q, bidx_d;
    logic [DW-1:0]     word_q, word_d, word_nx;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic              term_q, term_d;
    logic              err_q, err_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic              accept;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_state_q <= LD_ACTIVE;
            addr_q     <= '0;
            bidx_q     <= '0;
            word_q     <= '0;
            wc_q       <= '0;
            term_q     <= 1'b0;
            err_q      <= 1'b0;
            tmo_q      <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
        end else begin
            ld_state_q <= ld_state_d;
            addr_q     <= addr_d;
            bidx_q     <= bidx_d;
            word_q     <= word_d;
            wc_q       <= wc_d;
            term_q     <= term_d;
            err_q      <= err_d;
            tmo_q      <= tmo_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign accept = rx_valid && (ld_state_q == LD_ACTIVE);

    always_comb begin
        ld_state_d = ld_state_q;
        addr_d     = addr_q;
        bidx_d     = bidx_q;
        word_d     = word_q;
        wc_d       = wc_q;
        term_d     = term_q;
        err_d      = err_q;
        tmo_d      = tmo_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        word_nx    = word_q;
        word_nx[8*int'(bidx_q) +: 8] = rx_byte;

        if (rx_break) begin
            ld_state_d = LD_ACTIVE;
            addr_d     = '0;
            bidx_d     = '0;
            word_d     = '0;
            wc_d       = '0;
            term_d     = 1'b0;
            err_d      = 1'b0;
            tmo_d      = '0;
        end else begin
            if (rx_ferr) err_d = 1'b1;

            // A byte arriving on the expiry cycle takes priority and reloads the timer.
            if (accept) begin
                tmo_d = '0;
                if (bidx_q == BI_W'(WORD_BYTES - 1)) begin
                    we_d    = 1'b1;
                    waddr_d = addr_q;
                    wdata_d = word_nx;
                    bidx_d  = '0;
                    word_d  = '0;
                end else begin
                    word_d = word_nx;
                    bidx_d = bidx_q + BI_W'(1);
                end
            end else if (bidx_q != '0) begin
                if (tmo_q == TMO_W'(TMO_LIMIT - 1)) begin
                    tmo_d  = '0;
                    bidx_d = '0;
                    word_d = '0;
                    err_d  = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end else begin
                tmo_d = '0;
            end

            // Bookkeeping for the word being written happens in the strobe cycle.
            if (we_q) begin
                wc_d   = wc_q + WC_W'(1);
                term_d = (wdata_q == TERM_WORD);
                if ((wdata_q == TERM_WORD) && term_q) begin
                    ld_state_d = LD_DONE;
                end else if (addr_q == '1) begin
                    ld_state_d = LD_OVF;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end
        end
    end

    assign uart_rx_valid   = rx_valid;
    assign uart_rx_data    = rx_byte;
    assign uart_rx_break   = rx_break;
    assign imem.imem_we    = we_q;
    assign imem.imem_addr  = waddr_q;
    assign imem.imem_wdata = wdata_q;
    assign word_count      = wc_q;
    assign write_done      = (ld_state_q == LD_DONE);
    assign overflow        = (ld_state_q == LD_OVF);
    assign load_err        = err_q;
    assign ld_state_o      = ld_state_q;
endmodule

// File: tb/tb_uart_imem_loader.sv
// Self-checking bench for uart_imem_loader: randomized words against a word-level load model.
module tb_uart_imem_loader;
  import uart_loader_pkg::*;

  localparam int CLK_HZ     = 1600000;
  localparam int BIT_RATE   = 100000;
  localparam int CPB        = 16;
  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 3;
  localparam int DW         = 32;
  localparam int TIMEOUT_BITS = 64;
  localparam logic [DW-1:0] TERM = '1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic resetn;
  logic uart_rxd;
  logic uart_rx_en;
  logic uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic uart_rx_break;
  logic [ADDR_W:0] word_count;
  logic write_done;
  logic load_err;
  logic overflow;
  rx_state_e rx_state;
  ld_state_e ld_state;

  always #5 clk = ~clk;

  uart_imem_loader_if #(.ADDR_W(ADDR_W), .DW(DW)) imem_if ();

  uart_imem_loader #(
    .CLK_HZ(CLK_HZ), .BIT_RATE(BIT_RATE), .WORD_BYTES(WORD_BYTES),
    .ADDR_W(ADDR_W), .TERM_WORD(TERM), .TIMEOUT_BITS(TIMEOUT_BITS)
  ) dut (
    .clk(clk), .resetn(resetn), .uart_rxd(uart_rxd), .uart_rx_en(uart_rx_en),
    .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data), .uart_rx_break(uart_rx_break),
    .imem(imem_if), .word_count(word_count), .write_done(write_done),
    .load_err(load_err), .overflow(overflow), .rx_state_o(rx_state), .ld_state_o(ld_state)
  );

  int checks = 0;
  int fails  = 0;

  // ---------------- scoreboard ----------------
  logic [ADDR_W+DW-1:0] exp_q[$];
  logic [ADDR_W+DW-1:0] got_q[$];
  int rx_pulses, brk_pulses;
  int cyc, last_valid_cyc, last_we_cyc, last_lat, done_rise_cyc;
  logic prev_done;

  always @(negedge clk) begin
    cyc++;
    if (uart_rx_valid) begin
      rx_pulses++;
      last_valid_cyc = cyc;
    end
    if (uart_rx_break) brk_pulses++;
    if (imem_if.imem_we) begin
      got_q.push_back({imem_if.imem_addr, imem_if.imem_wdata});
      last_lat    = cyc - last_valid_cyc;
      last_we_cyc = cyc;
    end
    if (write_done && !prev_done) done_rise_cyc = cyc;
    prev_done = write_done;
  end

  // Word-level reference model of the load.
  int m_addr, m_wc;
  bit m_term, m_done, m_ovf;

  task automatic model_reset();
    m_addr = 0; m_wc = 0; m_term = 0; m_done = 0; m_ovf = 0;
    exp_q.delete();
  endtask

  task automatic model_word(input logic [DW-1:0] w);
    if (!m_done && !m_ovf) begin
      exp_q.push_back({m_addr[ADDR_W-1:0], w});
      m_wc++;
      if (w == TERM) begin
        if (m_term) m_done = 1;
        m_term = 1;
      end else begin
        m_term = 0;
      end
      if (!m_done) begin
        if (m_addr == (1 << ADDR_W) - 1) m_ovf = 1;
        else m_addr++;
      end
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    resetn = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    got_q.delete();
    rx_pulses = 0; brk_pulses = 0;
    model_reset();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rxd = stop_bit;
    repeat (CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    for (int k = 0; k < WORD_BYTES; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    resetn = 1'b0; uart_rxd = 1'b1; uart_rx_en = 1'b1;
    repeat (2) @(negedge clk);
    if ({uart_rx_valid, uart_rx_break, imem_if.imem_we} !== 3'b000) begin
      $display("FAIL reset_pulses got=%b exp=000", {uart_rx_valid, uart_rx_break, imem_if.imem_we}); fails++;
    end
    checks++;
    if ({uart_rx_data, imem_if.imem_addr, imem_if.imem_wdata, word_count} !== '0) begin
      $display("FAIL reset_buses data=%h addr=%h wdata=%h wc=%0d exp=0", uart_rx_data, imem_if.imem_addr, imem_if.imem_wdata, word_count); fails++;
    end
    checks++;
    if ({write_done, load_err, overflow} !== 3'b000) begin
      $display("FAIL reset_flags got=%b exp=000", {write_done, load_err, overflow}); fails++;
    end
    checks++;
    if (rx_state !== RX_IDLE || ld_state !== LD_ACTIVE) begin
      $display("FAIL reset_states rx=%0d ld=%0d exp=idle/active", rx_state, ld_state); fails++;
    end
    checks++;
    apply_reset();
  endtask

  task automatic test_single_word();
    apply_reset();
    send_word(32'hFC010113);
    model_word(32'hFC010113);
    if (got_q.size() !== 1) begin
      $display("FAIL t1_write_count got=%0d exp=1", got_q.size()); fails++;
    end
    checks++;
    if (got_q.size() > 0 && got_q[0] !== {3'd0, 32'hFC010113}) begin
      $display("FAIL t1_write got=%h exp=%h", got_q[0], {3'd0, 32'hFC010113}); fails++;
    end
    checks++;
    if (word_count !== 4'd1 || rx_pulses !== 4) begin
      $display("FAIL t1_counts wc=%0d rx=%0d exp wc=1 rx=4", word_count, rx_pulses); fails++;
    end
    checks++;
    if (last_lat !== 1) begin
      $display("FAIL t1_we_latency got=%0d exp=1", last_lat); fails++;
    end
    checks++;
    if (uart_rx_data !== 8'hFC) begin
      $display("FAIL t1_rx_data got=%h exp=fc", uart_rx_data); fails++;
    end
    checks++;
  endtask

  task automatic test_termination();
    logic [DW-1:0] words [5] = '{32'h00100793, 32'hFFFFFFFF, 32'h00000013, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [DW-1:0] extra;
    apply_reset();
    foreach (words[i]) begin
      send_word(words[i]);
      model_word(words[i]);
    end
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL t2_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); fails++;
    end
    checks++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL t2_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); fails++;
      end
      checks++;
    end
    if (write_done !== m_done) begin
      $display("FAIL t2_write_done got=%b exp=%b", write_done, m_done); fails++;
    end
    checks++;
    if (done_rise_cyc - last_we_cyc !== 1) begin
      $display("FAIL t2_done_latency got=%0d exp=1", done_rise_cyc - last_we_cyc); fails++;
    end
    checks++;
    extra = 32'h11223344;
    send_word(extra);
    model_word(extra);
    if (got_q.size() !== exp_q.size() || word_count !== 4'(m_wc)) begin
      $display("FAIL t2_after_done writes=%0d wc=%0d exp writes=%0d wc=%0d", got_q.size(), word_count, exp_q.size(), m_wc); fails++;
    end
    checks++;
    if (rx_pulses !== 24) begin
      $display("FAIL t2_rx_pulses got=%0d exp=24", rx_pulses); fails++;
    end
    checks++;
  endtask

  task automatic test_timeout();
    apply_reset();
    send_byte(8'($urandom), 1'b1);
    send_byte(8'($urandom), 1'b1);
    repeat ((TIMEOUT_BITS + 2) * CPB) @(negedge clk);
    if (load_err !== 1'b1) begin
      $display("FAIL t3_load_err got=%b exp=1", load_err); fails++;
    end
    checks++;
    send_word(32'hDDCCBBAA);
    model_word(32'hDDCCBBAA);
    if (got_q.size() !== 1 || (got_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      $display("FAIL t3_write n=%0d first=%h exp n=1 first=%h", got_q.size(), got_q.size() > 0 ? got_q[0] : '0, exp_q[0]); fails++;
    end
    checks++;
  endtask

  task automatic test_overflow();
    logic [DW-1:0] w;
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      w = $urandom;
      if (w == TERM) w = 32'h0;
      send_word(w);
      model_word(w);
    end
    if (got_q.size() !== 8) begin
      $display("FAIL t4_write_count got=%0d exp=8", got_q.size()); fails++;
    end
    checks++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL t4_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); fails++;
      end
      checks++;
    end
    if (overflow !== m_ovf || write_done !== 1'b0 || word_count !== 4'd8) begin
      $display("FAIL t4_flags ovf=%b done=%b wc=%0d exp ovf=%b done=0 wc=8", overflow, write_done, word_count, m_ovf); fails++;
    end
    checks++;
  endtask

  task automatic test_break();
    logic [DW-1:0] w;
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      send_word(w);
      model_word(w);
    end
    if (word_count !== 4'd3) begin
      $display("FAIL t5_wc_before got=%0d exp=3", word_count); fails++;
    end
    checks++;
    send_byte(8'h55, 1'b0);
    if (load_err !== 1'b1) begin
      $display("FAIL t5_ferr got=%b exp=1", load_err); fails++;
    end
    checks++;
    uart_rxd = 1'b0;
    repeat (12 * CPB) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (brk_pulses !== 1 || rx_pulses !== 12) begin
      $display("FAIL t5_break_pulse brk=%0d rx=%0d exp brk=1 rx=12", brk_pulses, rx_pulses); fails++;
    end
    checks++;
    if (word_count !== 4'd0 || {write_done, load_err, overflow} !== 3'b000) begin
      $display("FAIL t5_cleared wc=%0d flags=%b exp wc=0 flags=000", word_count, {write_done, load_err, overflow}); fails++;
    end
    checks++;
    model_reset();
    got_q.delete();
    w = $urandom;
    send_word(w);
    model_word(w);
    if (got_q.size() !== 1 || (got_q.size() > 0 && got_q[0] !== exp_q[0])) begin
      $display("FAIL t5_reload_write n=%0d exp n=1 word=%h", got_q.size(), exp_q[0]); fails++;
    end
    checks++;
  endtask

  task automatic test_random_stream();
    logic [DW-1:0] w;
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      w = ($urandom_range(0, 2) == 0) ? TERM : DW'($urandom);
      send_word(w);
      model_word(w);
    end
    if (got_q.size() !== exp_q.size()) begin
      $display("FAIL rnd_write_count got=%0d exp=%0d", got_q.size(), exp_q.size()); fails++;
    end
    checks++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      if (got_q[i] !== exp_q[i]) begin
        $display("FAIL rnd_write[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]); fails++;
      end
      checks++;
    end
    if (write_done !== m_done || overflow !== m_ovf || word_count !== 4'(m_wc) || load_err !== 1'b0) begin
      $display("FAIL rnd_flags done=%b ovf=%b wc=%0d err=%b exp done=%b ovf=%b wc=%0d err=0",
               write_done, overflow, word_count, load_err, m_done, m_ovf, m_wc); fails++;
    end
    checks++;
  endtask

  task automatic test_rx_frames();
    apply_reset();
    send_byte(8'hA5, 1'b1);
    if (rx_pulses !== 1 || uart_rx_data !== 8'hA5) begin
      $display("FAIL t6_good_byte rx=%0d data=%h exp rx=1 data=a5", rx_pulses, uart_rx_data); fails++;
    end
    checks++;
    uart_rx_en = 1'b0;
    send_byte(8'h3C, 1'b1);
    uart_rx_en = 1'b1;
    if (rx_pulses !== 1) begin
      $display("FAIL t6_rx_disabled rx=%0d exp=1", rx_pulses); fails++;
    end
    checks++;
    uart_rxd = 1'b0;
    repeat (4) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    if (rx_pulses !== 1 || rx_state !== RX_IDLE) begin
      $display("FAIL t6_glitch rx=%0d state=%0d exp rx=1 idle", rx_pulses, rx_state); fails++;
    end
    checks++;
    send_byte(8'h55, 1'b0);
    if (rx_pulses !== 1 || load_err !== 1'b1) begin
      $display("FAIL t6_frame_err rx=%0d err=%b exp rx=1 err=1", rx_pulses, load_err); fails++;
    end
    checks++;
    uart_rxd = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    resetn = 1'b0;
    #1;
    if ({uart_rx_valid, uart_rx_data, uart_rx_break, imem_if.imem_we, imem_if.imem_addr,
         imem_if.imem_wdata, word_count, write_done, load_err, overflow} !== '0 || rx_state !== RX_IDLE) begin
      $display("FAIL t6_async_reset data=%h err=%b wc=%0d state=%0d exp all 0", uart_rx_data, load_err, word_count, rx_state); fails++;
    end
    checks++;
    uart_rxd = 1'b1;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    cyc = 0; last_valid_cyc = 0; last_we_cyc = 0; last_lat = 0; done_rise_cyc = 0; prev_done = 0;
    rx_pulses = 0; brk_pulses = 0;
    test_reset();
    test_single_word();
    test_termination();
    test_timeout();
    test_overflow();
    test_break();
    test_random_stream();
    test_rx_frames();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Parametrised successor to the UART instruction-load path.
- Receives bytes over a UART RX line and assembles them little-endian into WORD_BYTES-wide words.
- Writes each word to instruction memory at incrementing addresses and flags completion on a double terminator word.
- Adds BREAK-triggered reload, inter-byte timeout, framing-error and depth-overflow detection; sits between the board RX pin and the imem write port, ahead of core reset release.

Parameters:
- CLK_HZ, 50000000, system clock frequency.
- BIT_RATE, 9600, UART bit rate; CLKS_PER_BIT = CLK_HZ/BIT_RATE (integer, >=4).
- WORD_BYTES, 4, bytes per instruction word (1..8); data width DW = 8*WORD_BYTES.
- ADDR_W, 8, imem word-address width; depth = 2^ADDR_W.
- TERM_WORD, all-ones of DW, terminator word value.
- TIMEOUT_BITS, 64, inter-byte timeout in bit periods while a word is partially assembled.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- uart_rxd  in  1  UART RX pin (idle high), asynchronous.
- uart_rx_en  in  1  receive enable.
- uart_rx_valid  out  1  one-cycle pulse, byte received.
- uart_rx_data  out  8  last received byte, held until next valid.
- uart_rx_break  out  1  one-cycle pulse, BREAK detected.
- imem_we  out  1  one-cycle write strobe.
- imem_addr  out  ADDR_W  word address of write.
- imem_wdata  out  DW  word data of write.
- word_count  out  ADDR_W+1  words written since load start.
- write_done  out  1  sticky, load complete.
- load_err  out  1  sticky, framing error or timeout seen.
- overflow  out  1  sticky, depth exhausted before terminator.

Behaviour:
- Reset (resetn low, async): all outputs 0; both FSMs IDLE; address, byte index and counters cleared.
- rxd passes through a 2-flop synchroniser, initialised high on reset.
- RX FSM: IDLE -> START on a synced falling edge, only when uart_rx_en=1.
- START: sample at CLKS_PER_BIT/2. If the line is high, treat as a glitch and return to IDLE. Otherwise go to DATA.
- DATA: 8 bits LSB-first, each sampled at mid-bit (every CLKS_PER_BIT).
- STOP: sample at mid-bit.
  - Stop=1: uart_rx_valid pulses the next cycle with uart_rx_data updated.
  - Stop=0 and data=0x00: uart_rx_break pulses instead. The FSM then waits for the line to return high before IDLE.
  - Stop=0 and data!=0: set load_err; no valid pulse.
- uart_rx_en deasserted mid-frame: the current frame completes; subsequent start edges are ignored.
- Loader: each valid byte is placed at byte lane byte_idx. When byte_idx reaches WORD_BYTES-1, the next cycle asserts imem_we for exactly 1 cycle with imem_addr = current address and imem_wdata = assembled word.
  - Address and word_count then increment; byte_idx returns to 0.
  - Latency: imem_we fires 1 cycle after the valid pulse of the last byte.
- Termination: write_done sets when TERM_WORD is written on two consecutive words. Both terminators are written. Any non-terminator word between them resets the match.
- After write_done or overflow, further bytes still pulse uart_rx_valid but produce no imem writes.
- Depth: when the write to address 2^ADDR_W-1 completes without termination, set overflow; address does not wrap.
- Timeout: when byte_idx!=0 and no valid byte arrives for TIMEOUT_BITS*CLKS_PER_BIT cycles, discard the partial word (byte_idx=0) and set load_err. The address is unchanged.
- BREAK: restarts the load. Address, byte_idx, word_count, terminator match, write_done, load_err and overflow are all cleared in the break-pulse cycle.
- Simultaneous timeout expiry and byte valid: the byte wins and the timer reloads.

Decomposition:
- Shared package uart_loader_pkg:
  - RX state enum {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH}.
  - Loader state enum {LD_ACTIVE, LD_DONE, LD_OVF}.
  - Helper constant for CLKS_PER_BIT.
- One sub-module, uart_rx_core: synchroniser plus RX FSM, producing the valid, data, break and frame_err outputs.
- Word assembly, counters and timeout stay in the top.

Test Plan (CLK_HZ=1600000, BIT_RATE=100000 -> 16 clk/bit; WORD_BYTES=4; ADDR_W=3):
1. Send bytes 13 01 01 FC -> one imem_we, addr 0, wdata 0xFC010113; word_count=1; uart_rx_valid pulsed 4 times.
2. Send words 0x00100793, 0xFFFFFFFF, 0x00000013, 0xFFFFFFFF, 0xFFFFFFFF -> 5 writes at addr 0..4; write_done rises 1 cycle after the 5th write; then send 0x11223344 -> no write.
3. Send 2 bytes, idle 64 bit periods, then send 4 bytes AA BB CC DD -> load_err=1; single write 0xDDCCBBAA at addr 0.
4. Write 8 non-terminator words -> addr 0..7 written; overflow=1 after addr 7; 9th word not written.
5. Load 3 words, hold rxd low for 12 bit times -> uart_rx_break pulse; word_count=0, flags clear; next word is written at addr 0.
6. Start bit glitch of 4 clk low -> no valid pulse. Frame with stop bit 0 and data 0x55 -> load_err=1, no valid. Assert resetn low mid-frame -> all outputs 0 immediately.
